// File: rtl/cart_mem_pkg.sv
// Shared constants for the cartridge/loader external memory arbiter.
package cart_mem_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_ACCESS  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    localparam logic GNT_GB = 1'b0;
    localparam logic GNT_LD = 1'b1;

    localparam int DEF_ADDR_W         = 24;
    localparam int DEF_ACCESS_CYCLES  = 3;
    localparam int DEF_RECOVER_CYCLES = 1;
    localparam int DEF_STARVE_LIMIT   = 4;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cart_mem_prio_sel.sv
// Fixed cartridge priority with a saturating starvation counter for the loader.
module cart_mem_prio_sel
    import cart_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic vb_clk,
    input  logic vb_rst_n,
    input  logic arbitrate,
    input  logic gb_req,
    input  logic ld_req,
    output logic gnt_valid,
    output logic gnt_winner
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt_reg;
    logic [SW-1:0] starve_cnt_next;
    logic          starved;

    assign starved    = (starve_cnt_reg == STARVE_MAX);
    assign gnt_valid  = arbitrate && (gb_req || ld_req);
    assign gnt_winner = (ld_req && (!gb_req || starved)) ? GNT_LD : GNT_GB;

    // Only a cartridge win over a waiting loader advances the count.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (arbitrate) begin
            if (!ld_req || (gnt_winner == GNT_LD)) begin
                starve_cnt_next = '0;
            end else if (!starved) begin
                starve_cnt_next = starve_cnt_reg + SW'(1);
            end
        end
    end

    always_ff @(posedge vb_clk or negedge vb_rst_n) begin
        if (!vb_rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Two-port arbiter sequencing setup/strobe/recovery phases on an async byte-wide memory bus.
module cart_mem_arbiter
    import cart_mem_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ACCESS_CYCLES  = DEF_ACCESS_CYCLES,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
    input  logic              vb_clk,
    input  logic              vb_rst_n,
    input  logic              gb_req,
    input  logic              gb_we,
    input  logic [ADDR_W-1:0] gb_addr,
    input  logic [7:0]        gb_wdata,
    output logic [7:0]        gb_rdata,
    output logic              gb_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic [7:0]        ld_rdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dq_o,
    output logic              mem_dq_oe,
    input  logic [7:0]        mem_dq_i,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              grant,
    output logic              busy
);

    localparam int CNT_MAX = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;
    logic              grant_reg;
    logic              gnt_valid;
    logic              gnt_winner;
    logic              access_done;
    logic              in_strobe;

    cart_mem_prio_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_sel (
        .vb_clk    (vb_clk),
        .vb_rst_n  (vb_rst_n),
        .arbitrate (state_reg == S_IDLE),
        .gb_req    (gb_req),
        .ld_req    (ld_req),
        .gnt_valid (gnt_valid),
        .gnt_winner(gnt_winner)
    );

    assign access_done = (state_reg == S_ACCESS) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (gnt_valid) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                state_next = S_ACCESS;
                cnt_next   = ACC_LOAD;
            end
            S_ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = S_RECOVER;
                    cnt_next   = REC_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_RECOVER: begin
                if (cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The winner's request is frozen here so the requester may move on mid-access.
    always_ff @(posedge vb_clk or negedge vb_rst_n) begin
        if (!vb_rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            grant_reg <= GNT_GB;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (gnt_valid) begin
                grant_reg <= gnt_winner;
                we_reg    <= (gnt_winner == GNT_LD) ? ld_we    : gb_we;
                addr_reg  <= (gnt_winner == GNT_LD) ? ld_addr  : gb_addr;
                wdata_reg <= (gnt_winner == GNT_LD) ? ld_wdata : gb_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic       ack_reg;
        logic [7:0] rdata_reg;
        logic       owner;

        assign owner = (grant_reg == 1'(gi));

        always_ff @(posedge vb_clk or negedge vb_rst_n) begin
            if (!vb_rst_n) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= access_done && owner;
                if (access_done && owner && !we_reg) begin
                    rdata_reg <= mem_dq_i;
                end
            end
        end
    end

    assign gb_ack   = g_port[0].ack_reg;
    assign gb_rdata = g_port[0].rdata_reg;
    assign ld_ack   = g_port[1].ack_reg;
    assign ld_rdata = g_port[1].rdata_reg;

    // Strobes decode straight from state so reset releases the bus immediately.
    assign in_strobe = (state_reg == S_SETUP) || (state_reg == S_ACCESS);
    assign mem_ce_n  = !in_strobe;
    assign mem_oe_n  = !(in_strobe && !we_reg);
    assign mem_we_n  = !((state_reg == S_ACCESS) && we_reg);
    assign mem_dq_oe = in_strobe && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_dq_o  = wdata_reg;
    assign grant     = grant_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed and random checks of cart_mem_arbiter against a transaction-level timing model.
module tb_cart_mem_arbiter;

    localparam int AW     = 24;
    localparam int ACC    = 3;
    localparam int REC    = 1;
    localparam int LIM    = 4;
    localparam int PERIOD = 2 + ACC + REC;

    logic          vb_clk;
    logic          vb_rst_n;
    logic          gb_req, gb_we, ld_req, ld_we;
    logic [AW-1:0] gb_addr, ld_addr;
    logic [7:0]    gb_wdata, ld_wdata, gb_rdata, ld_rdata;
    logic          gb_ack, ld_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dq_o, mem_dq_i;
    logic          mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, grant, busy;

    cart_mem_arbiter #(
        .ADDR_W(AW), .ACCESS_CYCLES(ACC), .RECOVER_CYCLES(REC), .STARVE_LIMIT(LIM)
    ) dut (
        .vb_clk(vb_clk), .vb_rst_n(vb_rst_n),
        .gb_req(gb_req), .gb_we(gb_we), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_rdata(gb_rdata), .gb_ack(gb_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe), .mem_dq_i(mem_dq_i),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .grant(grant), .busy(busy)
    );

    initial vb_clk = 1'b0;
    always #5 vb_clk = ~vb_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction-level model of the bus owner and the requesters' view
    bit            have_txn;
    int            t_g;
    int            free_at;
    int            starve;
    logic          m_port, m_we;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_wdata;
    logic          last_grant;
    logic [7:0]    exp_rd [2];
    logic [7:0]    dq_last;

    int ev_cyc[$];
    int ev_port[$];
    int ev_gnt[$];
    int n_ce, n_we, n_oe, n_dqo_ok;
    bit keep_gb, keep_ld, rand_mode, rd_only, fixed_dq_en;
    logic [7:0] fixed_dq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        have_txn   = 1'b0;
        free_at    = 0;
        starve     = 0;
        last_addr  = '0;
        last_wdata = '0;
        last_grant = 1'b0;
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
    endtask

    // Decide what happens at the end of the current cycle from the levels now on the inputs.
    task automatic model_arb();
        logic win;
        if (!vb_rst_n) begin
            model_reset();
            return;
        end
        if (cyc >= free_at) begin
            if (gb_req || ld_req) begin
                win = ld_req && (!gb_req || starve == LIM);
                if (!ld_req || win) starve = 0;
                else if (starve < LIM) starve = starve + 1;
                have_txn   = 1'b1;
                t_g        = cyc;
                m_port     = win;
                m_we       = win ? ld_we : gb_we;
                last_addr  = win ? ld_addr : gb_addr;
                last_wdata = win ? ld_wdata : gb_wdata;
                last_grant = win;
                free_at    = cyc + PERIOD;
            end else begin
                starve  = 0;
                free_at = cyc + 1;
            end
        end
    endtask

    task automatic check_outputs();
        int   k;
        logic in_w, su, ac, ackc;
        k    = cyc - t_g;
        in_w = have_txn && (k >= 1) && (k <= 1 + ACC + REC);
        su   = in_w && (k == 1);
        ac   = in_w && (k >= 2) && (k <= 1 + ACC);
        ackc = in_w && (k == 2 + ACC);
        if (ackc && !m_we) exp_rd[m_port] = dq_last;
        chk("mem_ce_n",  32'(mem_ce_n),  32'(!(su || ac)));
        chk("mem_oe_n",  32'(mem_oe_n),  32'(!((su || ac) && !m_we)));
        chk("mem_we_n",  32'(mem_we_n),  32'(!(ac && m_we)));
        chk("mem_dq_oe", 32'(mem_dq_oe), 32'((su || ac) && m_we));
        if ((su || ac) && m_we) chk("mem_dq_o", 32'(mem_dq_o), 32'(last_wdata));
        chk("mem_addr",  32'(mem_addr),  32'(last_addr));
        chk("busy",      32'(busy),      32'(in_w));
        chk("grant",     32'(grant),     32'(last_grant));
        chk("gb_ack",    32'(gb_ack),    32'(ackc && m_port == 1'b0));
        chk("ld_ack",    32'(ld_ack),    32'(ackc && m_port == 1'b1));
        chk("gb_rdata",  32'(gb_rdata),  32'(exp_rd[0]));
        chk("ld_rdata",  32'(ld_rdata),  32'(exp_rd[1]));
    endtask

    task automatic tick();
        model_arb();
        @(posedge vb_clk);
        @(negedge vb_clk);
        cyc++;
        check_outputs();
        mem_dq_i = fixed_dq_en ? fixed_dq : 8'($urandom);
        if (have_txn && (cyc - t_g == 1 + ACC)) dq_last = mem_dq_i;
        if (mem_ce_n === 1'b0) n_ce++;
        if (mem_we_n === 1'b0) n_we++;
        if (mem_oe_n === 1'b0) n_oe++;
        if (mem_dq_oe === 1'b1 && mem_dq_o === 8'h3C) n_dqo_ok++;
    endtask

    task automatic new_op(input int p);
        logic          w;
        logic [AW-1:0] a;
        logic [7:0]    d;
        w = rd_only ? 1'b0 : 1'($urandom);
        a = AW'($urandom);
        d = 8'($urandom);
        if (p == 0) begin
            gb_req = 1'b1; gb_we = w; gb_addr = a; gb_wdata = d;
        end else begin
            ld_req = 1'b1; ld_we = w; ld_addr = a; ld_wdata = d;
        end
    endtask

    task automatic clear_ev();
        ev_cyc.delete();
        ev_port.delete();
        ev_gnt.delete();
        n_ce = 0; n_we = 0; n_oe = 0; n_dqo_ok = 0;
    endtask

    task automatic run(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            tick();
            if (gb_ack === 1'b1) begin
                ev_cyc.push_back(cyc); ev_port.push_back(0); ev_gnt.push_back(int'(grant));
                if (rand_mode) keep_gb = 1'($urandom);
                if (keep_gb) new_op(0); else gb_req = 1'b0;
            end
            if (ld_ack === 1'b1) begin
                ev_cyc.push_back(cyc); ev_port.push_back(1); ev_gnt.push_back(int'(grant));
                if (rand_mode) keep_ld = 1'($urandom);
                if (keep_ld) new_op(1); else ld_req = 1'b0;
            end
            if (rand_mode) begin
                k = cyc - t_g;
                if (!gb_req && $urandom_range(0, 2) == 0) new_op(0);
                if (!ld_req && $urandom_range(0, 2) == 0) new_op(1);
                // After its grant a requester is free to scramble its inputs.
                if (have_txn && k >= 1 && k <= 1 + ACC && $urandom_range(0, 1) == 0) begin
                    if (m_port == 1'b0) begin
                        gb_addr = AW'($urandom); gb_wdata = 8'($urandom); gb_we = 1'($urandom);
                    end else begin
                        ld_addr = AW'($urandom); ld_wdata = 8'($urandom); ld_we = 1'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        keep_gb = 1'b0;
        keep_ld = 1'b0;
        rand_mode = 1'b0;
        run(2 * PERIOD + 10);
    endtask

    initial begin
        int c0;
        int r;
        int exp_g [6];
        exp_g = '{0, 0, 0, 0, 1, 0};

        vb_rst_n = 1'b0;
        gb_req = 0; gb_we = 0; gb_addr = '0; gb_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        mem_dq_i = '0;
        keep_gb = 0; keep_ld = 0; rand_mode = 0; rd_only = 0; fixed_dq_en = 0; fixed_dq = '0;
        dq_last = '0; t_g = 0;
        model_reset();
        clear_ev();
        run(2);
        chk("rst_mem_dq_o", 32'(mem_dq_o), 32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_ce_n",     32'(mem_ce_n), 32'h1);
        vb_rst_n = 1'b1;
        run(2);

        // Single cartridge read
        fixed_dq_en = 1'b1; fixed_dq = 8'hA5;
        clear_ev();
        c0 = cyc;
        gb_req = 1; gb_we = 0; gb_addr = 24'h004123; gb_wdata = 8'h00;
        run(8);
        chk("t1_acks",     32'(ev_cyc.size()), 32'd1);
        chk("t1_latency",  32'((ev_cyc.size() > 0) ? ev_cyc[0] - c0 : -1), 32'd5);
        chk("t1_ce_cycles", 32'(n_ce), 32'd4);
        chk("t1_gb_rdata", 32'(gb_rdata), 32'hA5);
        chk("t1_ld_rdata", 32'(ld_rdata), 32'h00);
        fixed_dq_en = 1'b0;

        // Single loader write
        clear_ev();
        c0 = cyc;
        ld_req = 1; ld_we = 1; ld_addr = 24'h7FC000; ld_wdata = 8'h3C;
        run(8);
        chk("t2_acks",      32'(ev_cyc.size()), 32'd1);
        chk("t2_port",      32'((ev_port.size() > 0) ? ev_port[0] : -1), 32'd1);
        chk("t2_latency",   32'((ev_cyc.size() > 0) ? ev_cyc[0] - c0 : -1), 32'd5);
        chk("t2_we_cycles", 32'(n_we), 32'd3);
        chk("t2_oe_cycles", 32'(n_oe), 32'd0);
        chk("t2_dqo_cycles", 32'(n_dqo_ok), 32'd4);
        chk("t2_gb_rdata",  32'(gb_rdata), 32'hA5);

        // Both ports requesting continuously
        clear_ev();
        new_op(0); new_op(1);
        keep_gb = 1; keep_ld = 1;
        run(36);
        chk("t3_acks", 32'(ev_cyc.size()), 32'd6);
        for (int i = 0; i < ev_gnt.size() && i < 6; i++) begin
            chk("t3_grant_seq", 32'(ev_gnt[i]), 32'(exp_g[i]));
            if (i > 0) chk("t3_spacing", 32'(ev_cyc[i] - ev_cyc[i-1]), 32'(PERIOD));
        end
        drain();

        // Input change while the access is in flight
        clear_ev();
        gb_req = 1; gb_we = 0; gb_addr = 24'h000100;
        run(2);
        gb_addr = 24'h000200;
        run(2);
        chk("t4_addr_access", 32'(mem_addr), 32'h000100);
        run(3);
        chk("t4_addr_hold", 32'(mem_addr), 32'h000100);
        chk("t4_acks", 32'(ev_cyc.size()), 32'd1);

        // Reset in the second strobe cycle of a write, with the loader waiting
        gb_req = 1; gb_we = 1; gb_addr = AW'($urandom); gb_wdata = 8'h5A;
        new_op(1);
        keep_gb = 0; keep_ld = 1;
        run(3);
        chk("t5_we_before", 32'(mem_we_n), 32'h0);
        vb_rst_n = 1'b0;
        #1;
        chk("t5_ce_n",   32'(mem_ce_n),  32'h1);
        chk("t5_oe_n",   32'(mem_oe_n),  32'h1);
        chk("t5_we_n",   32'(mem_we_n),  32'h1);
        chk("t5_dq_oe",  32'(mem_dq_oe), 32'h0);
        chk("t5_busy",   32'(busy),      32'h0);
        chk("t5_addr",   32'(mem_addr),  32'h0);
        chk("t5_gb_ack", 32'(gb_ack),    32'h0);
        clear_ev();
        run(2);
        vb_rst_n = 1'b1;
        r = cyc;
        keep_gb = 1;
        run(31);
        chk("t5_acks", 32'(ev_cyc.size()), 32'd5);
        chk("t5_first_ack", 32'((ev_cyc.size() > 0) ? ev_cyc[0] - r : -1), 32'd5);
        for (int i = 0; i < ev_gnt.size() && i < 5; i++) begin
            chk("t5_grant_seq", 32'(ev_gnt[i]), 32'(exp_g[i]));
        end
        drain();

        // Back-to-back cartridge reads with req held across the ack
        clear_ev();
        rd_only = 1;
        new_op(0);
        keep_gb = 1;
        run(24);
        chk("t6_acks", 32'(ev_cyc.size()), 32'd4);
        for (int i = 1; i < ev_cyc.size(); i++) begin
            chk("t6_spacing", 32'(ev_cyc[i] - ev_cyc[i-1]), 32'(PERIOD));
        end
        rd_only = 0;
        drain();

        // Random mixed traffic
        clear_ev();
        rand_mode = 1;
        run(600);
        chk("rand_traffic", 32'(ev_cyc.size() > 40), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares one external asynchronous SRAM/flash-style byte bus between two requesters.
- The Game Boy cartridge path (MBC-translated ROM/RAM address) has priority. The loader path (ROM image download, save backup) runs in the background.
- Sequences each access through setup, strobe and recovery phases with programmable wait states, and returns read data with a one-cycle acknowledge.
- A starvation guard ensures the loader still progresses under continuous cartridge traffic.

Parameters:
- ADDR_W, 24, byte address width of the external memory (ROM bank bits plus RAM region).
- ACCESS_CYCLES, 3, strobe-active cycles per access; minimum 1.
- RECOVER_CYCLES, 1, strobe-inactive cycles after each access; minimum 1.
- STARVE_LIMIT, 4, consecutive cartridge grants allowed while the loader waits.

Ports:
- vb_clk  in  1  system clock
- vb_rst_n  in  1  reset, asynchronous, active-low
- gb_req  in  1  cartridge request, level, held until gb_ack
- gb_we  in  1  1 = write, 0 = read
- gb_addr  in  ADDR_W  cartridge byte address
- gb_wdata  in  8  cartridge write data
- gb_rdata  out  8  cartridge read data
- gb_ack  out  1  one-cycle completion pulse
- ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_ack  same directions, widths and meanings, for the loader
- mem_addr  out  ADDR_W  external address
- mem_dq_o  out  8  external write data
- mem_dq_oe  out  1  data bus drive enable
- mem_dq_i  in  8  external read data
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low strobes
- grant  out  1  owner of the current or last access (0 = gb, 1 = ld)
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, SETUP, ACCESS, RECOVER.
- Reset (asynchronous, any state): state IDLE.
  - mem_ce_n, mem_oe_n, mem_we_n = 1; mem_dq_oe = 0; mem_addr = 0; mem_dq_o = 0.
  - gb_rdata = ld_rdata = 0; acks = 0; grant = 0; busy = 0; starvation counter = 0.
  - Reset mid-access abandons the access; no ack is issued.
- Arbitration happens in IDLE only, on the current req levels:
  - gb only -> gb wins.
  - ld only -> ld wins.
  - both requesting -> gb wins unless starve_cnt == STARVE_LIMIT, in which case ld wins.
- starve_cnt:
  - increments when gb is granted while ld_req = 1, saturating at STARVE_LIMIT;
  - clears when ld is granted, or when arbitration happens with ld_req = 0.
- On grant, the winner's we/addr/wdata are latched and grant is updated. Later changes on the inputs do not affect the access in flight.
- Timing, with the request seen in IDLE at cycle t:
  - SETUP at t+1: mem_addr driven, mem_ce_n = 0; mem_oe_n = 0 for reads; mem_dq_oe = 1 with mem_dq_o driven for writes.
  - ACCESS from t+2 to t+1+ACCESS_CYCLES: ce_n = 0, oe_n as in SETUP; mem_we_n = 0 for writes only. The cycle counter runs down from ACCESS_CYCLES-1 to 0.
  - mem_dq_i is sampled at the clock edge ending the last ACCESS cycle into the winner's rdata register. The other port's rdata is unchanged.
  - RECOVER from t+2+ACCESS_CYCLES: all strobes = 1, mem_dq_oe = 0, mem_addr held. The winner's ack is high for the first RECOVER cycle only.
  - After RECOVER_CYCLES cycles -> IDLE.
- Latency from request to ack is 2+ACCESS_CYCLES cycles (5 at defaults). Throughput is one access per 2+ACCESS_CYCLES+RECOVER_CYCLES cycles (6 at defaults), because IDLE takes one cycle.
- Requesters drop req in the cycle after ack. A req still high when IDLE is re-entered counts as a new request, so back-to-back traffic is legal.
- rdata holds its value until that port's next read completes. Writes do not modify rdata.
- mem_we_n and mem_oe_n are never low in the same cycle. mem_dq_oe is never high during a read.
- The arbiter enforces no address ranges; it treats both ports identically apart from priority.

Decomposition:
- Shared package/header cart_mem_pkg holds:
  - state encoding constants (S_IDLE, S_SETUP, S_ACCESS, S_RECOVER);
  - grant encoding (GNT_GB = 0, GNT_LD = 1);
  - default timing constants.
- One sub-module, cart_mem_prio_sel, holds the priority decision plus starve_cnt.
  - Inputs: gb_req, ld_req, an arbitrate strobe.
  - Outputs: a valid grant and the winner.

Test Plan:
- Single gb read: gb_addr = 0x004123, mem_dq_i = 0xA5 during ACCESS.
  - Required: mem_ce_n low for cycles t+1 to t+4; gb_ack only at t+5; gb_rdata = 0xA5; ld_rdata stays 0.
- Single ld write: ld_addr = 0x7FC000, ld_wdata = 0x3C.
  - Required: mem_dq_oe = 1 with mem_dq_o = 0x3C during SETUP and ACCESS; mem_we_n low for exactly 3 cycles; mem_oe_n stays 1; ld_ack 1 cycle.
- Both ports requesting continuously.
  - Required grant sequence: gb, gb, gb, gb, ld, then gb again; ack spacing exactly 6 cycles.
- Input change mid-access: gb_addr changes from 0x000100 to 0x000200 during ACCESS.
  - Required: mem_addr stays 0x000100 until the next grant.
- Reset mid-access: drive vb_rst_n low during the 2nd ACCESS cycle of a write.
  - Required: strobes go high and mem_dq_oe drops to 0 immediately (asynchronous); no ack; after release, state IDLE and starve_cnt = 0.
- Back-to-back gb reads with req held high across the ack.
  - Required: the second access starts in the IDLE cycle after RECOVER; acks 6 cycles apart; rdata updates on each ack.
